// File: rtl/uart_tx_buf.sv
// Buffered UART transmitter: an 8-entry (by default) circular FIFO feeding an
// 8N1 serializer that runs frames back-to-back while bytes remain queued.
module uart_tx_buf #(
    parameter int CLK_PER_HALF_BIT = 5208,
    parameter int FIFO_AW          = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] sdata,
    input  logic       tx_start,
    output logic       tx_ready,
    output logic       txd,
    output logic       tx_busy,
    output logic       ovf
);

    localparam int              DEPTH    = 1 << FIFO_AW;
    localparam logic [31:0]     BIT_LAST = 32'(2 * CLK_PER_HALF_BIT - 1);
    localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               state_q, state_d;
    logic [31:0]          cnt_q, cnt_d;
    logic [2:0]           idx_q, idx_d;
    logic [7:0]           shreg_q, shreg_d;
    logic [FIFO_AW-1:0]   wptr_q, wptr_d;
    logic [FIFO_AW-1:0]   rptr_q, rptr_d;
    logic [FIFO_AW:0]     count_q, count_d;
    logic                 txd_q, txd_d;
    logic                 ready_q, ready_d;
    logic                 busy_q, busy_d;
    logic                 ovf_q, ovf_d;
    logic [7:0]           mem [DEPTH];

    logic push, pop, bit_end, fifo_empty;

    assign push       = tx_start & ready_q;
    assign bit_end    = (cnt_q == BIT_LAST);
    assign fifo_empty = (count_q == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            txd_q   <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            txd_q   <= txd_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr_q] <= sdata;
    end

    // Next-state: popping at the end of STOP chains frames with no idle gap.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 32'd1;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shreg_d = mem[rptr_q];
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (idx_q == 3'd7) state_d = STOP;
                    else               idx_d   = idx_q + 3'd1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shreg_d = mem[rptr_q];
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wptr_d  = push ? wptr_q + FIFO_AW'(1) : wptr_q;
        rptr_d  = pop  ? rptr_q + FIFO_AW'(1) : rptr_q;
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (FIFO_AW + 1)'(1);
            2'b01:   count_d = count_q - (FIFO_AW + 1)'(1);
            default: count_d = count_q;
        endcase
        ready_d = (count_d != FULL_CNT);
        ovf_d   = ovf_q | (tx_start & ~ready_q);
    end

    // Outputs are registered from next state so txd changes on the transition edge.
    always_comb begin
        txd_d = 1'b1;
        case (state_d)
            IDLE:    txd_d = 1'b1;
            START:   txd_d = 1'b0;
            DATA:    txd_d = shreg_d[idx_d];
            STOP:    txd_d = 1'b1;
            default: txd_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE) || (count_d != '0);
    end

    assign txd      = txd_q;
    assign tx_ready = ready_q;
    assign tx_busy  = busy_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_uart_tx_buf.sv
// Directed bench for uart_tx_buf with an 8-clock bit period.
module tb_uart_tx_buf;

    localparam int BP = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] sdata;
    logic       tx_start;
    logic       tx_ready, txd, tx_busy, ovf;

    int errors = 0;
    int checks = 0;

    uart_tx_buf #(.CLK_PER_HALF_BIT(4), .FIFO_AW(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .sdata    (sdata),
        .tx_start (tx_start),
        .tx_ready (tx_ready),
        .txd      (txd),
        .tx_busy  (tx_busy),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected line level m clocks after the start bit began.
    function automatic logic bit_at(input logic [7:0] b, input int m);
        int k;
        k = m / BP;
        if (k == 0)      return 1'b0;
        else if (k <= 8) return b[k-1];
        else             return 1'b1;
    endfunction

    task automatic expect_range(input logic [7:0] b, input int from, input int upto);
        for (int m = from; m < upto; m++) begin
            chk($sformatf("txd byte=%02h m=%0d", b, m), {31'd0, txd}, {31'd0, bit_at(b, m)});
            tick();
        end
    endtask

    task automatic expect_idle(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            chk(tag, {30'd0, txd, tx_busy}, {30'd0, 1'b1, 1'b0});
            tick();
        end
    endtask

    initial begin
        rst      = 1'b1;
        sdata    = 8'h00;
        tx_start = 1'b0;
        #2;
        chk("rst txd",   {31'd0, txd},      32'd1);
        chk("rst ready", {31'd0, tx_ready}, 32'd1);
        chk("rst busy",  {31'd0, tx_busy},  32'd0);
        chk("rst ovf",   {31'd0, ovf},      32'd0);
        #10 rst = 1'b0;
        tick();

        // Single frame 0xA5 from idle
        sdata = 8'hA5; tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
        chk("a5 txd before start", {31'd0, txd},     32'd1);
        chk("a5 busy",             {31'd0, tx_busy}, 32'd1);
        tick();
        expect_range(8'hA5, 0, 10*BP);
        chk("a5 busy done", {31'd0, tx_busy},  32'd0);
        chk("a5 ready",     {31'd0, tx_ready}, 32'd1);
        expect_idle(10, "a5 idle");

        // Ten back-to-back writes: nine accepted, tenth overflows
        for (int j = 0; j < 10; j++) begin
            sdata = 8'(j); tx_start = 1'b1;
            chk($sformatf("burst ready j=%0d", j), {31'd0, tx_ready}, (j < 9) ? 32'd1 : 32'd0);
            tick();
        end
        tx_start = 1'b0;
        chk("burst ovf",       {31'd0, ovf},      32'd1);
        chk("burst ready low", {31'd0, tx_ready}, 32'd0);
        expect_range(8'h00, BP, 10*BP);
        for (int b = 1; b < 9; b++) expect_range(8'(b), 0, 10*BP);
        chk("burst busy done", {31'd0, tx_busy}, 32'd0);
        expect_idle(20, "burst no 0x09");
        chk("burst ovf sticky", {31'd0, ovf}, 32'd1);

        // Write 0x3C during the stop bit of 0xFF
        sdata = 8'hFF; tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
        tick();
        expect_range(8'hFF, 0, 9*BP);
        sdata = 8'h3C; tx_start = 1'b1;
        expect_range(8'hFF, 9*BP, 9*BP + 1);
        tx_start = 1'b0;
        expect_range(8'hFF, 9*BP + 1, 10*BP);
        expect_range(8'h3C, 0, 10*BP);
        chk("3c busy done", {31'd0, tx_busy}, 32'd0);
        expect_idle(5, "3c idle");
        chk("ovf still set", {31'd0, ovf}, 32'd1);

        // Reset during data bit 3 of 0x55 with two bytes queued
        sdata = 8'h55; tx_start = 1'b1;
        tick();
        sdata = 8'h11;
        tick();
        sdata = 8'h22;
        tick();
        tx_start = 1'b0;
        expect_range(8'h55, 1, 4*BP + 3);
        chk("pre-rst busy", {31'd0, tx_busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mid rst txd",   {31'd0, txd},      32'd1);
        chk("mid rst busy",  {31'd0, tx_busy},  32'd0);
        chk("mid rst ready", {31'd0, tx_ready}, 32'd1);
        chk("mid rst ovf",   {31'd0, ovf},      32'd0);
        #2 rst = 1'b0;
        tick();
        expect_idle(100, "post rst idle");

        // Full FIFO: a write coinciding with a pop is dropped
        for (int i = 0; i < 9; i++) begin
            sdata = 8'hC0 + 8'(i); tx_start = 1'b1;
            tick();
        end
        tx_start = 1'b0;
        chk("full ready", {31'd0, tx_ready}, 32'd0);
        chk("full ovf",   {31'd0, ovf},      32'd0);
        expect_range(8'hC0, 7, 10*BP - 1);
        sdata = 8'hEE; tx_start = 1'b1;
        expect_range(8'hC0, 10*BP - 1, 10*BP);
        tx_start = 1'b0;
        chk("collide ovf",   {31'd0, ovf},      32'd1);
        chk("collide ready", {31'd0, tx_ready}, 32'd1);
        for (int i = 1; i < 9; i++) expect_range(8'hC0 + 8'(i), 0, 10*BP);
        chk("collide busy done", {31'd0, tx_busy}, 32'd0);
        expect_idle(20, "no 0xEE");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
